// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the RV32I pipeline.
// Holds the PC, issues one outstanding request at a time to instruction
// memory and hands fetched words to decode through an IF/ID register backed
// by a one-entry skid buffer. Supports decode stalls and execute redirects.
// Optional feature: define IF_ALIGN_CHECK_EN to flag misaligned redirect
// targets on out_misaligned instead of silently aligning them.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        out_misaligned
`endif
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN
    } state_t;

    state_t      state;
    logic        started;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_insn;
    logic [31:0] skid_pc;
    logic        halted;

    logic        handshake;
    logic        deliver;
    logic        consume;
    logic        out_free;
    logic        drain_pending;
    logic [31:0] redirect_target;

    // Requests are held off during the reset cycle itself, while the skid
    // buffer is occupied, and while parked on a misaligned redirect.
    assign imem_req_valid  = started && (state == FETCH) && !skid_valid && !halted;
    assign imem_addr       = fetch_pc;
    assign handshake       = imem_req_valid && imem_req_ready;
    assign deliver         = (state == WAIT) && imem_resp_valid;
    assign consume         = out_valid && !stall;
    assign out_free        = !out_valid || !stall;
    // A response is still owed to us if one was just accepted, or if we were
    // already waiting and it has not arrived this cycle.
    assign drain_pending   = handshake || ((state != FETCH) && !imem_resp_valid);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign out_pc_plus4    = out_pc + 32'd4;

`ifdef IF_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |redirect_pc[1:0];
`else
    assign halted = 1'b0;
`endif

    // Fetch FSM, PC, skid buffer and IF/ID output register.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= FETCH;
            started         <= 1'b0;
            fetch_pc        <= RESET_PC;
            req_pc          <= RESET_PC;
            skid_valid      <= 1'b0;
            // NOTE: payload registers are reset too; it is cheap here and
            // keeps unknowns off the decode interface.
            skid_insn       <= NOP_INSN;
            skid_pc         <= 32'h0;
            out_valid       <= 1'b0;
            out_instruction <= NOP_INSN;
            out_pc          <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            halted          <= 1'b0;
            out_misaligned  <= 1'b0;
`endif
        end else begin
            started <= 1'b1;
            if (flush) begin
                // Redirect wins over stall and delivery; any in-flight
                // response is dropped by DRAIN.
                state           <= drain_pending ? DRAIN : FETCH;
                fetch_pc        <= redirect_target;
                skid_valid      <= 1'b0;
                out_valid       <= 1'b0;
                out_instruction <= NOP_INSN;
`ifdef IF_ALIGN_CHECK_EN
                halted          <= misaligned;
                out_misaligned  <= misaligned;
                if (misaligned) begin
                    out_valid <= 1'b1;
                    out_pc    <= redirect_pc;
                end
`endif
            end else begin
                case (state)
                    FETCH: begin
                        if (handshake) begin
                            fetch_pc <= fetch_pc + 32'd4;
                            req_pc   <= fetch_pc;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_resp_valid) state <= FETCH;
                    end
                    DRAIN: begin
                        if (imem_resp_valid) state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase

                // Output register: a fresh word takes priority when the
                // register is free; otherwise drain the skid on consumption.
                if (deliver && out_free) begin
                    out_valid       <= 1'b1;
                    out_instruction <= imem_resp_data;
                    out_pc          <= req_pc;
                end else if (consume) begin
                    if (skid_valid) begin
                        out_instruction <= skid_insn;
                        out_pc          <= skid_pc;
                        skid_valid      <= 1'b0;
                    end else begin
                        out_valid       <= 1'b0;
                        out_instruction <= NOP_INSN;
                    end
                end

                // Decode is stalled on a valid word: park the new one.
                if (deliver && !out_free) begin
                    skid_valid <= 1'b1;
                    skid_insn  <= imem_resp_data;
                    skid_pc    <= req_pc;
                end

`ifdef IF_ALIGN_CHECK_EN
                if (consume) out_misaligned <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the five-stage RV32I pipeline, upstream of the decode stage. It holds the program counter, issues single-outstanding requests to instruction memory over a valid/ready handshake, and presents fetched instructions to decode through an IF/ID output register backed by a one-entry skid buffer. It supports decode-side stalls and branch/jump redirect (flush).

## Interface
- RESET_PC, 32'h0000_0000: PC fetched first after reset.
- NOP_INSN, 32'h0000_0013: value driven on out_instruction when no instruction is valid (addi x0,x0,0).

- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode cannot accept; output register holds.
- flush  in  1  redirect request from execute; has priority over stall.
- redirect_pc  in  32  new PC, sampled when flush=1.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (word aligned).
- imem_resp_valid  in  1  response data valid, exactly one per accepted request, ≥1 cycle after acceptance.
- imem_resp_data  in  32  fetched instruction word.
- out_valid  out  1  IF/ID register holds a valid instruction.
- out_instruction  out  32  instruction to decode.
- out_pc  out  32  PC of out_instruction.
- out_pc_plus4  out  32  out_pc + 4 (modulo 2^32).

## Operation
- Internal: fetch_pc (next address to request), skid buffer (valid, insn, pc), FSM.
- FSM states:
  - FETCH: imem_req_valid = !skid_valid; imem_addr = fetch_pc. On valid&&ready: fetch_pc += 4, capture request PC, go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid: deliver word (below), go to FETCH.
  - DRAIN: imem_req_valid=0. On imem_resp_valid: discard word, go to FETCH.
- Delivery: output register is free if !out_valid or (out_valid && !stall). Free -> word loads output register. Not free -> word loads skid buffer.
- Consumption: on out_valid && !stall, output register loads skid buffer contents if skid_valid (skid cleared), else clears out_valid unless a response is delivered that cycle.
- Response in same cycle as consumption with skid full: cannot occur (request suppressed while skid_valid).
- Flush (cycle N): out_valid and skid_valid clear; fetch_pc <= redirect_pc. If state is WAIT, or a request handshake completes in cycle N, next state is DRAIN; otherwise FETCH. A response arriving in cycle N is discarded. Flush overrides stall and delivery.
- PC arithmetic is 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values: imem_req_valid=0 while reset low, state FETCH, fetch_pc=RESET_PC, out_valid=0, out_instruction=NOP_INSN, out_pc=0, out_pc_plus4=4, skid empty.
- First request: first clock edge after reset release, imem_req_valid=1, imem_addr=RESET_PC.
- Response at cycle N -> out_valid=1 and out_instruction valid in N+1; next request (PC+4) issued in N+1.
- Peak throughput: one instruction per 2 cycles with 1-cycle memory.
- imem_req_valid, once high, stays high with stable imem_addr until ready, except when flush lowers it.
- Reset mid-transaction: all state returns to reset values immediately; any later response from memory is the memory's responsibility to cancel.
- When out_valid=0, out_instruction=NOP_INSN.

## Configuration
- IF_ALIGN_CHECK_EN defined: redirect_pc with bits[1:0]≠0 raises output out_misaligned (1 bit, reset 0) with out_valid=1, out_instruction=NOP_INSN, out_pc=redirect_pc, one cycle after flush; no fetch is issued until the next flush.
- Not defined: no out_misaligned port; redirect_pc[1:0] forced to 2'b00.

## Test plan
- Reset release, memory ready=1, 1-cycle latency, words 0xA0,0xA1,0xA2 -> requests at 0x0,0x4,0x8; out_pc 0x0,0x4,0x8 with matching instructions, out_valid every other cycle.
- stall=1 for 5 cycles after first delivery -> out_instruction/out_pc frozen, second word held in skid, no third request; stall=0 -> skid word emitted next cycle, then fetch at 0x8.
- imem_req_ready=0 for 3 cycles -> imem_req_valid and imem_addr=0x0 stable; accepted on 4th.
- flush with redirect_pc=0x100 while WAIT (response for 0x4 pending) -> that response discarded, next request addr 0x100, next out_pc=0x100.
- flush and stall same cycle, out_valid=1 -> out_valid=0 next cycle, redirect honoured.
- redirect_pc=0xFFFF_FFFC -> request 0xFFFF_FFFC then 0x0; out_pc_plus4=0x0.
